// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file and its hazard scoreboard.
// Optional same-edge write-to-read forwarding is enabled by REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_NUM_RD = 2;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set on issue, cleared by write-back, issue wins a tie.
// Lookups expose either the current (pre-edge) or next (post-edge) pending value.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W      = REGFILE_ADDR_W,
    parameter int NUM_RD      = REGFILE_NUM_RD,
    parameter bit LOOKUP_POST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issEn,
    input  logic [ADDR_W-1:0]        issAddr,
    input  logic [1:0]               wrEn,
    input  logic [2*ADDR_W-1:0]      wrAddr,
    input  logic [NUM_RD*ADDR_W-1:0] lookupAddr,
    output logic [NUM_RD-1:0]        lookupBusy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pendNext;

    // Clears are applied first so that a same-cycle issue overrides them.
    always_comb begin
        pendNext = pending;
        if (wrEn[0]) pendNext[wrAddr[0 +: ADDR_W]] = 1'b0;
        if (wrEn[1]) pendNext[wrAddr[ADDR_W +: ADDR_W]] = 1'b0;
        if (issEn) pendNext[issAddr] = 1'b1;
        pendNext[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pendNext;
        end
    end

    always_comb begin
        lookupBusy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (LOOKUP_POST) begin
                lookupBusy[i] = pendNext[lookupAddr[i*ADDR_W +: ADDR_W]];
            end else begin
                lookupBusy[i] = pending[lookupAddr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, two write-back ports
// (port 1 wins collisions), r0 hard-wired to zero. REGFILE_BYPASS_EN forwards same-edge writes.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int NUM_RD = REGFILE_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [1:0]               wr_en,
    input  logic [2*ADDR_W-1:0]      wr_addr,
    input  logic [2*DATA_W-1:0]      wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [ADDR_W-1:0] wrAddr0;
    logic [ADDR_W-1:0] wrAddr1;
    logic [DATA_W-1:0] wrData0;
    logic [DATA_W-1:0] wrData1;
    logic              wrHit0;
    logic              wrHit1;
    logic [NUM_RD-1:0] lookupBusy;
    logic [DATA_W-1:0] mem [DEPTH];

    assign wrAddr0 = wr_addr[0 +: ADDR_W];
    assign wrAddr1 = wr_addr[ADDR_W +: ADDR_W];
    assign wrData0 = wr_data[0 +: DATA_W];
    assign wrData1 = wr_data[DATA_W +: DATA_W];
    assign wrHit0  = wr_en[0] && (wrAddr0 != ADDR_W'(REG_ZERO));
    assign wrHit1  = wr_en[1] && (wrAddr1 != ADDR_W'(REG_ZERO));

    regfile_scoreboard #(
        .ADDR_W      (ADDR_W),
        .NUM_RD      (NUM_RD),
        .LOOKUP_POST (BYPASS)
    ) uScoreboard (
        .clk        (clk),
        .rst        (rst),
        .issEn      (iss_en),
        .issAddr    (iss_addr),
        .wrEn       (wr_en),
        .wrAddr     (wr_addr),
        .lookupAddr (rd_addr),
        .lookupBusy (lookupBusy)
    );

    // Port 1 is assigned last so it wins when both ports target one register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            if (wrHit0) mem[wrAddr0] <= wrData0;
            if (wrHit1) mem[wrAddr1] <= wrData1;
        end
    end

    // Value a read port captures at this edge; r0 never matches a write hit.
    function automatic logic [DATA_W-1:0] readValue(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        value = mem[addr];
`ifdef REGFILE_BYPASS_EN
        if (wrHit1 && (wrAddr1 == addr)) begin
            value = wrData1;
        end else if (wrHit0 && (wrAddr0 == addr)) begin
            value = wrData0;
        end
`endif
        return value;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_data[i*DATA_W +: DATA_W] <= readValue(rd_addr[i*ADDR_W +: ADDR_W]);
                rd_busy[i]                  <= lookupBusy[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (4 x 64-bit read ports); expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 4;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [1:0]       wr_en;
    logic [2*AW-1:0]  wr_addr;
    logic [2*DW-1:0]  wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;

    int total = 0;
    int bad   = 0;

    int            expLane [$];
    logic [DW-1:0] expData [$];
    logic          expBusy [$];
    string         expTag  [$];

    regfile_mp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic doWrite(input int port, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_en[port]             = 1'b1;
        wr_addr[port*AW +: AW]  = addr;
        wr_data[port*DW +: DW]  = data;
    endtask

    task automatic doIssue(input logic [AW-1:0] addr);
        iss_en   = 1'b1;
        iss_addr = addr;
    endtask

    task automatic doRead(input int lane, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic busy, input string tag);
        rd_addr[lane*AW +: AW] = addr;
        expLane.push_back(lane);
        expData.push_back(data);
        expBusy.push_back(busy);
        expTag.push_back(tag);
    endtask

    task automatic checkOutput();
        while (expLane.size() > 0) begin
            int            lane;
            logic [DW-1:0] d;
            logic          b;
            string         tag;
            logic [DW-1:0] gotD;
            lane = expLane.pop_front();
            d    = expData.pop_front();
            b    = expBusy.pop_front();
            tag  = expTag.pop_front();
            gotD = rd_data[lane*DW +: DW];
            total++;
            assert (gotD === d) else begin
                bad++;
                $error("[TB] FAIL %s data lane %0d got=%h exp=%h", tag, lane, gotD, d);
            end
            total++;
            assert (rd_busy[lane] === b) else begin
                bad++;
                $error("[TB] FAIL %s busy lane %0d got=%b exp=%b", tag, lane, rd_busy[lane], b);
            end
        end
    endtask

    task automatic checkReset(input string tag);
        total++;
        assert (rd_data === '0) else begin
            bad++;
            $error("[TB] FAIL %s rd_data got=%h exp=0", tag, rd_data);
        end
        total++;
        assert (rd_busy === '0) else begin
            bad++;
            $error("[TB] FAIL %s rd_busy got=%b exp=0", tag, rd_busy);
        end
    endtask

    // One clock edge: compare everything queued for this edge, then idle the write/issue ports.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        checkOutput();
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        #1 rst = 1'b1;
        #2 checkReset("initRst");
        #3 rst = 1'b0;
        $display("[TB] reset released");

        doWrite(0, 20, 64'd50);
        applyStimulus();
        doRead(1, 20, 64'd50, 1'b0, "wr20");
        applyStimulus();

        doWrite(0, 0, 64'd7);
        applyStimulus();
        doRead(0, 0, 64'd0, 1'b0, "wr0");
        applyStimulus();

        doWrite(0, 9, 64'd1);
        doWrite(1, 9, 64'd2);
        applyStimulus();
        doRead(2, 9, 64'd2, 1'b0, "collide");
        applyStimulus();

        doWrite(0, 10, 64'd10);
        doWrite(1, 11, 64'd11);
        applyStimulus();
        doRead(0, 10, 64'd10, 1'b0, "dual10");
        doRead(3, 11, 64'd11, 1'b0, "dual11");
        applyStimulus();

        doIssue(12);
        applyStimulus();
        doRead(0, 12, 64'd0, 1'b1, "iss12");
        applyStimulus();
        doWrite(0, 12, 64'd99);
        applyStimulus();
        doRead(0, 12, 64'd99, 1'b0, "wb12");
        applyStimulus();
        doWrite(1, 12, 64'd100);
        doIssue(12);
        applyStimulus();
        doRead(0, 12, 64'd100, 1'b1, "isswr12");
        applyStimulus();

        doWrite(0, 12, 64'd55);
        doRead(1, 12, BYP ? 64'd55 : 64'd100, BYP ? 1'b0 : 1'b1, "sameClr");
        applyStimulus();
        doRead(1, 12, 64'd55, 1'b0, "afterClr");
        applyStimulus();

        doIssue(13);
        doRead(2, 13, 64'd0, BYP, "sameIss");
        applyStimulus();
        doRead(2, 13, 64'd0, 1'b1, "afterIss");
        applyStimulus();

        doIssue(0);
        applyStimulus();
        doRead(0, 0, 64'd0, 1'b0, "iss0");
        applyStimulus();

        doIssue(14);
        applyStimulus();
        doIssue(14);
        applyStimulus();
        doWrite(1, 14, 64'd7);
        applyStimulus();
        doRead(3, 14, 64'd7, 1'b0, "dblIss");
        applyStimulus();

        doWrite(0, 3, 64'd4);
        applyStimulus();
        doWrite(0, 3, 64'hDEAD);
        doRead(0, 3, BYP ? 64'hDEAD : 64'd4, 1'b0, "sameWr3");
        applyStimulus();
        doRead(0, 3, 64'hDEAD, 1'b0, "afterWr3");
        applyStimulus();

        doWrite(0, 21, 64'h1111_2222_3333_4444);
        doWrite(1, 22, 64'h5555_6666_7777_8888);
        applyStimulus();
        doWrite(0, 23, 64'h9999_AAAA_BBBB_CCCC);
        doWrite(1, 24, 64'hDDDD_EEEE_FFFF_0123);
        applyStimulus();
        doRead(0, 24, 64'hDDDD_EEEE_FFFF_0123, 1'b0, "lane0");
        doRead(1, 23, 64'h9999_AAAA_BBBB_CCCC, 1'b0, "lane1");
        doRead(2, 22, 64'h5555_6666_7777_8888, 1'b0, "lane2");
        doRead(3, 21, 64'h1111_2222_3333_4444, 1'b0, "lane3");
        applyStimulus();

        doWrite(0, 5, 64'h55);
        doIssue(6);
        applyStimulus();
        for (int l = 0; l < NR; l++) doRead(l, 5, 64'h55, 1'b0, "pre5");
        applyStimulus();
        #2 rst = 1'b1;
        #1 checkReset("midRst");
        #2 rst = 1'b0;

        for (int a = 1; a < 32; a++) begin
            doRead((a - 1) % NR, AW'(a), 64'd0, 1'b0, "postRst");
            if (((a - 1) % NR == NR - 1) || (a == 31)) applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS pipeline with hazard scoreboard. Replaces the fixed 32x32, two-read, one-write file. Adds:
- a configurable number of registered read ports;
- two prioritised write-back ports;
- asynchronous clear;
- a per-register pending bit that lets decode stall on in-flight producers.

Register 0 is hard-wired to zero.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  registered pending flag of the addressed register
- wr_en  in  2  write enables, ports 0 and 1
- wr_addr  in  2*ADDR_W  write addresses
- wr_data  in  2*DATA_W  write data
- iss_en  in  1  an instruction issuing a future write to iss_addr
- iss_addr  in  ADDR_W  destination of the issuing instruction

## Operation
- **Reset** (asserted): every register = 0, every pending bit = 0, rd_data = 0, rd_busy = 0. Takes effect immediately, independent of clk.
- **Write**: on a rising edge, reg[wr_addr[p]] <= wr_data[p] for each p with wr_en[p]=1.
- **Write collision**: if both ports target the same address, port 1 (the later pipeline stage) wins.
- **Register 0**: writes to address 0 are ignored on both ports.
- **Read**: each port samples rd_addr on the rising edge. rd_data shows the stored value after that edge.
- **Read of address 0**: always returns 0 with rd_busy=0.
- **Scoreboard**: iss_en=1 with iss_addr≠0 sets pending[iss_addr].
- **Pending clear**: any enabled write to address A clears pending[A].
- **Issue/write to same register in one cycle**: set has priority; pending stays 1, because a new producer is in flight.
- **Issue to address 0**: ignored.
- **Pending bit width**: one bit, not a counter. A second issue to an already-pending register leaves it at 1. The first write to that register clears it; the pipeline guarantees in-order write-back per register.
- **rd_busy**: follows the same bypass rule as rd_data (see Configuration).

## Timing
- Read latency is 1 cycle: address at edge N, data and busy valid from edge N until edge N+1.
- Write latency is 1 cycle: data written at edge N is visible to a read sampled at edge N+1.
- Same-edge read and write of the same address: governed by REGFILE_BYPASS_EN.
- Pending set or clear at edge N is reflected in rd_busy for reads sampled at edge N+1. With bypass it is also reflected for reads sampled at edge N.
- No combinational path from inputs to outputs.
- Reset deassertion is synchronised externally; the block needs no recovery cycle.

## Configuration
- **REGFILE_BYPASS_EN defined**: a read sampling address A at the same edge as an enabled write to A (A≠0) returns the new wr_data.
  - If both ports write A, port 1's data is returned.
  - rd_busy returns the post-edge pending value.
- **Not defined**: the same read returns the pre-write stored value and pre-edge pending value. Forwarding is then the pipeline's responsibility.

## Structure
- Package regfile_pkg holds:
  - default constants REGFILE_DATA_W=32, REGFILE_ADDR_W=5, REGFILE_NUM_RD=2;
  - the constant REG_ZERO = 0.
- Sub-module regfile_scoreboard holds:
  - the 2**ADDR_W pending bits;
  - the set/clear/priority logic;
  - NUM_RD lookup outputs.
- The storage array, write priority, read registers and bypass muxing live in regfile_mp.

## Test plan
- Reset mid-run after writes, all ports addr 5 → rd_data=0 and rd_busy=0 immediately; reads of regs 1..31 return 0 after release.
- Write reg 20=50 on port 0; next edge read port 1 addr 20 → rd_data=50. Write reg 0=7 → read 0 returns 0.
- Same edge: port 0 writes r9=1, port 1 writes r9=2 → subsequent read r9 = 2.
- iss r12 → read r12 next cycle busy=1. Write r12=99 → busy=0, data=99. Issue and write r12 on the same edge → busy stays 1.
- Same-edge write r3=0xDEAD and read r3 (old value 4):
  - bypass build → 0xDEAD;
  - non-bypass build → 4, then 0xDEAD on the following read.
- NUM_RD=4, DATA_W=64: four distinct addresses read simultaneously → each returns its own 64-bit value with no lane crosstalk.
